// File: rtl/pwm_cfg_sequencer_pkg.sv
// pwm_cfg_pkg: types and constants shared by the PWM configuration sequencer
//   CFG_W           value width of period and compare registers
//   ADDR_*          host register map (6 and 7 are reserved)
//   state_t         sequencer FSM states
//   pwm_cfg_t       one complete period/compare set (shadow or active)
//   CFG_RST         reset contents of both sets
package pwm_cfg_pkg;
    localparam int CFG_W = 18;
    localparam logic [2:0] ADDR_PRD    = 3'd0;
    localparam logic [2:0] ADDR_CMP0H  = 3'd1;
    localparam logic [2:0] ADDR_CMP0L  = 3'd2;
    localparam logic [2:0] ADDR_CMP1H  = 3'd3;
    localparam logic [2:0] ADDR_CMP1L  = 3'd4;
    localparam logic [2:0] ADDR_COMMIT = 3'd5;
    typedef enum logic [1:0] {IDLE, CHECK, ARMED} state_t;
    typedef struct packed {
        logic [CFG_W-1:0] prd;
        logic [CFG_W-1:0] cmp0h;
        logic [CFG_W-1:0] cmp0l;
        logic [CFG_W-1:0] cmp1h;
        logic [CFG_W-1:0] cmp1l;
    } pwm_cfg_t;
    localparam pwm_cfg_t CFG_RST = '{
        prd:   CFG_W'(8),
        cmp0h: CFG_W'(0),
        cmp0l: CFG_W'(5),
        cmp1h: CFG_W'(4),
        cmp1l: CFG_W'(3)
    };
endpackage

// File: rtl/pwm_cfg_sequencer_if.sv
// pwm_cfg_if: host write bus, timebase reload strobe and active configuration
//   wr_valid/wr_ready/wr_addr/wr_data  host register write handshake
//   tb_zero                            PWM timebase reload cycle
//   prd, cmp0h, cmp0l, cmp1h, cmp1l    active configuration
//   busy, upd_done, cfg_err            sequencer status
//   master: host/timebase side, slave: sequencer side
interface pwm_cfg_if #(parameter int WIDTH = 18);
    logic             wr_valid;
    logic             wr_ready;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             tb_zero;
    logic [WIDTH-1:0] prd;
    logic [WIDTH-1:0] cmp0h;
    logic [WIDTH-1:0] cmp0l;
    logic [WIDTH-1:0] cmp1h;
    logic [WIDTH-1:0] cmp1l;
    logic             busy;
    logic             upd_done;
    logic             cfg_err;
    modport master (
        output wr_valid, wr_addr, wr_data, tb_zero,
        input  wr_ready, prd, cmp0h, cmp0l, cmp1h, cmp1l, busy, upd_done, cfg_err
    );
    modport slave (
        input  wr_valid, wr_addr, wr_data, tb_zero,
        output wr_ready, prd, cmp0h, cmp0l, cmp1h, cmp1l, busy, upd_done, cfg_err
    );
endinterface

// File: rtl/pwm_cfg_sequencer_check.sv
// pwm_cfg_check: combinational legality check of one configuration set
//   cfg_i  candidate set
//   ok_o   1 when prd >= 1 and every compare value <= prd
module pwm_cfg_check
    import pwm_cfg_pkg::*;
(
    input  pwm_cfg_t cfg_i,
    output logic     ok_o
);
    assign ok_o = (cfg_i.prd != '0) && (cfg_i.cmp0h <= cfg_i.prd) && (cfg_i.cmp0l <= cfg_i.prd)
                  && (cfg_i.cmp1h <= cfg_i.prd) && (cfg_i.cmp1l <= cfg_i.prd);
endmodule

// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer: shadow/active PWM configuration with checked, zero-aligned commit
//   clk, rst   system clock, synchronous active-high reset
//   bus        pwm_cfg_if slave: host writes, tb_zero, active set and status
module pwm_cfg_sequencer
    import pwm_cfg_pkg::*;
#(
    parameter int WIDTH = CFG_W
) (
    input logic     clk,
    input logic     rst,
    pwm_cfg_if.slave bus
);
    generate
        if (WIDTH != CFG_W) begin : g_width_chk
            $error("WIDTH must equal pwm_cfg_pkg::CFG_W");
        end
    endgenerate

    state_t   state_q, state_d;
    pwm_cfg_t shd_q, shd_d, act_q, act_d;
    logic     upd_done_q, upd_done_d, cfg_err_q, cfg_err_d;
    logic     ok;

    pwm_cfg_check u_check (.cfg_i(shd_q), .ok_o(ok));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shd_q      <= CFG_RST;
            act_q      <= CFG_RST;
            upd_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shd_q      <= shd_d;
            act_q      <= act_d;
            upd_done_q <= upd_done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shd_d      = shd_q;
        act_d      = act_q;
        upd_done_d = 1'b0;
        cfg_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.wr_valid) begin
                    case (bus.wr_addr)
                        ADDR_PRD:    shd_d.prd   = bus.wr_data;
                        ADDR_CMP0H:  shd_d.cmp0h = bus.wr_data;
                        ADDR_CMP0L:  shd_d.cmp0l = bus.wr_data;
                        ADDR_CMP1H:  shd_d.cmp1h = bus.wr_data;
                        ADDR_CMP1L:  shd_d.cmp1l = bus.wr_data;
                        ADDR_COMMIT: state_d     = CHECK;
                        default:     cfg_err_d   = 1'b1;
                    endcase
                end
            end
            // tb_zero is deliberately ignored here; the swap only happens from ARMED
            CHECK: begin
                state_d   = ok ? ARMED : IDLE;
                cfg_err_d = !ok;
            end
            ARMED: begin
                if (bus.tb_zero) begin
                    act_d      = shd_q;
                    upd_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.wr_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.upd_done = upd_done_q;
    assign bus.cfg_err  = cfg_err_q;
    assign bus.prd      = act_q.prd;
    assign bus.cmp0h    = act_q.cmp0h;
    assign bus.cmp0l    = act_q.cmp0l;
    assign bus.cmp1h    = act_q.cmp1h;
    assign bus.cmp1l    = act_q.cmp1l;
endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// tb_pwm_cfg_sequencer: scoreboard bench for pwm_cfg_sequencer
module tb_pwm_cfg_sequencer;
    import pwm_cfg_pkg::*;

    typedef struct {
        bit       err;
        pwm_cfg_t cfg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    pwm_cfg_t act;

    always #5 clk = ~clk;

    pwm_cfg_if #(.WIDTH(18)) bus();
    pwm_cfg_sequencer #(.WIDTH(18)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign act = {bus.prd, bus.cmp0h, bus.cmp0l, bus.cmp1h, bus.cmp1l};

    function automatic pwm_cfg_t mk(input int p, input int a, input int b, input int c, input int d);
        return {18'(p), 18'(a), 18'(b), 18'(c), 18'(d)};
    endfunction

    function automatic exp_t ex_upd(input pwm_cfg_t c);
        return '{err: 1'b0, cfg: c};
    endfunction

    function automatic exp_t ex_err();
        return '{err: 1'b1, cfg: '0};
    endfunction

    always @(negedge clk) begin
        if (!rst && (bus.upd_done || bus.cfg_err)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: upd_done=%0b cfg_err=%0b with no event expected", bus.upd_done, bus.cfg_err);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.cfg_err !== mon_e.err || bus.upd_done !== !mon_e.err || (!mon_e.err && act !== mon_e.cfg)) begin
                    bad++;
                    $display("FAIL sb_event: got upd=%0b err=%0b act=%h want err=%0b act=%h",
                             bus.upd_done, bus.cfg_err, act, mon_e.err, mon_e.cfg);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] a, input logic [17:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wr_valid = 1'b0;
        bus.tb_zero  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (act !== mk(8, 0, 5, 4, 3)) begin bad++; $display("FAIL reset_act: got %h want %h", act, mk(8, 0, 5, 4, 3)); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.wr_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if ({bus.upd_done, bus.cfg_err} !== 2'b00) begin bad++; $display("FAIL reset_pulses: got %b want 00", {bus.upd_done, bus.cfg_err}); end
    endtask

    task automatic test_update();
        write(ADDR_PRD, 18'd20);
        write(ADDR_CMP0L, 18'd10);
        total++; if (act !== mk(8, 0, 5, 4, 3)) begin bad++; $display("FAIL upd_shadow_only: got %h want defaults", act); end
        exp_q.push_back(ex_upd(mk(20, 0, 10, 4, 3)));
        write(ADDR_COMMIT, 18'd0);
        for (int i = 0; i < 10; i++) begin
            total++; if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin bad++; $display("FAIL upd_busy[%0d]: got busy=%b ready=%b want 1 0", i, bus.busy, bus.wr_ready); end
            total++; if (act !== mk(8, 0, 5, 4, 3)) begin bad++; $display("FAIL upd_hold[%0d]: got %h want defaults", i, act); end
            tick();
        end
        bus.tb_zero = 1'b1;
        tick();
        bus.tb_zero = 1'b0;
        total++; if (act !== mk(20, 0, 10, 4, 3)) begin bad++; $display("FAIL upd_load: got %h want %h", act, mk(20, 0, 10, 4, 3)); end
        total++; if (bus.upd_done !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL upd_done: got done=%b busy=%b want 1 0", bus.upd_done, bus.busy); end
        tick();
        total++; if (bus.upd_done !== 1'b0) begin bad++; $display("FAIL upd_once: got %b want 0", bus.upd_done); end
    endtask

    task automatic test_reject();
        do_reset();
        write(ADDR_PRD, 18'd4);
        exp_q.push_back(ex_err());
        write(ADDR_COMMIT, 18'd0);
        total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL rej_early: got %b want 0", bus.cfg_err); end
        tick();
        total++; if (bus.cfg_err !== 1'b1 || bus.upd_done !== 1'b0) begin bad++; $display("FAIL rej_err: got err=%b upd=%b want 1 0", bus.cfg_err, bus.upd_done); end
        total++; if (bus.prd !== 18'd8 || bus.busy !== 1'b0) begin bad++; $display("FAIL rej_keep: got prd=%0d busy=%b want 8 0", bus.prd, bus.busy); end
        write(ADDR_CMP0L, 18'd2);
        exp_q.push_back(ex_upd(mk(4, 0, 2, 4, 3)));
        write(ADDR_COMMIT, 18'd0);
        bus.tb_zero = 1'b1;
        tick();
        total++; if (bus.upd_done !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL rej_check_ignores_zero: got upd=%b busy=%b want 0 1", bus.upd_done, bus.busy); end
        tick();
        bus.tb_zero = 1'b0;
        total++; if (bus.upd_done !== 1'b1 || act !== mk(4, 0, 2, 4, 3)) begin bad++; $display("FAIL rej_recommit: got upd=%b act=%h want 1 %h", bus.upd_done, act, mk(4, 0, 2, 4, 3)); end
        tick();
    endtask

    task automatic test_latency();
        bus.tb_zero = 1'b1;
        exp_q.push_back(ex_upd(mk(4, 0, 2, 4, 3)));
        write(ADDR_COMMIT, 18'd0);
        total++; if (bus.wr_ready !== 1'b0 || bus.upd_done !== 1'b0) begin bad++; $display("FAIL lat_c1: got ready=%b upd=%b want 0 0", bus.wr_ready, bus.upd_done); end
        tick();
        total++; if (bus.wr_ready !== 1'b0 || bus.upd_done !== 1'b0) begin bad++; $display("FAIL lat_c2: got ready=%b upd=%b want 0 0", bus.wr_ready, bus.upd_done); end
        tick();
        total++; if (bus.wr_ready !== 1'b1 || bus.upd_done !== 1'b1) begin bad++; $display("FAIL lat_c3: got ready=%b upd=%b want 1 1", bus.wr_ready, bus.upd_done); end
        bus.tb_zero = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(ex_upd(mk(4, 0, 2, 4, 3)));
        write(ADDR_COMMIT, 18'd0);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = ADDR_PRD;
        bus.wr_data  = 18'd50;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 0", i, bus.wr_ready); end
        end
        bus.tb_zero = 1'b1;
        tick();
        bus.tb_zero = 1'b0;
        total++; if (bus.upd_done !== 1'b1 || act !== mk(4, 0, 2, 4, 3)) begin bad++; $display("FAIL b2b_load: got upd=%b act=%h want 1 %h", bus.upd_done, act, mk(4, 0, 2, 4, 3)); end
        tick();
        bus.wr_valid = 1'b0;
        total++; if (act !== mk(4, 0, 2, 4, 3) || bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_shadow_only: got act=%h busy=%b", act, bus.busy); end
        bus.tb_zero = 1'b1;
        exp_q.push_back(ex_upd(mk(50, 0, 2, 4, 3)));
        write(ADDR_COMMIT, 18'd0);
        tick();
        tick();
        bus.tb_zero = 1'b0;
        total++; if (act !== mk(50, 0, 2, 4, 3)) begin bad++; $display("FAIL b2b_accepted: got %h want %h", act, mk(50, 0, 2, 4, 3)); end
        tick();
    endtask

    task automatic test_reserved();
        exp_q.push_back(ex_err());
        write(3'd7, 18'd123);
        total++; if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0 || act !== mk(50, 0, 2, 4, 3)) begin bad++; $display("FAIL rsv7: got err=%b busy=%b act=%h", bus.cfg_err, bus.busy, act); end
        exp_q.push_back(ex_err());
        write(3'd6, 18'd0);
        total++; if (bus.cfg_err !== 1'b1 || bus.wr_ready !== 1'b1) begin bad++; $display("FAIL rsv6: got err=%b ready=%b want 1 1", bus.cfg_err, bus.wr_ready); end
        bus.tb_zero = 1'b1;
        exp_q.push_back(ex_upd(mk(50, 0, 2, 4, 3)));
        write(ADDR_COMMIT, 18'd0);
        tick();
        tick();
        bus.tb_zero = 1'b0;
        total++; if (bus.upd_done !== 1'b1 || act !== mk(50, 0, 2, 4, 3)) begin bad++; $display("FAIL rsv_shadow: got upd=%b act=%h", bus.upd_done, act); end
        tick();
    endtask

    task automatic test_reset_armed();
        write(ADDR_PRD, 18'd30);
        write(ADDR_COMMIT, 18'd0);
        tick();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_armed_busy: got %b want 1", bus.busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.upd_done !== 1'b0 || act !== mk(8, 0, 5, 4, 3)) begin bad++; $display("FAIL rst_armed: got busy=%b upd=%b act=%h", bus.busy, bus.upd_done, act); end
        bus.tb_zero = 1'b1;
        tick();
        total++; if (bus.upd_done !== 1'b0) begin bad++; $display("FAIL rst_no_pending: got %b want 0", bus.upd_done); end
        exp_q.push_back(ex_upd(mk(8, 0, 5, 4, 3)));
        write(ADDR_COMMIT, 18'd0);
        tick();
        tick();
        bus.tb_zero = 1'b0;
        total++; if (bus.upd_done !== 1'b1 || act !== mk(8, 0, 5, 4, 3)) begin bad++; $display("FAIL rst_shadow: got upd=%b act=%h", bus.upd_done, act); end
        tick();
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.tb_zero  = 1'b0;
        test_reset();
        test_update();
        test_reject();
        test_latency();
        test_back_to_back();
        test_reserved();
        test_reset_armed();
        tick();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_drain: %0d expected events never seen, want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_cfg_sequencer.md
Name: pwm_cfg_sequencer

Overview:
- Host-facing configuration controller for the PWM timebase and its two output-compare channels (I/Q pairs).
- Host writes period and compare values into shadow registers, then issues a commit.
- The block checks the shadow set for consistency, then waits for timebase zero.
- It copies the whole shadow set into the active registers atomically on that cycle, so the PWM never sees a torn configuration mid-period.

Parameters:
- WIDTH, 18, width of timebase, period and compare values.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- wr_valid  input  1  host write request
- wr_ready  output  1  block can accept a write this cycle
- wr_addr  input  3  register select
- wr_data  input  WIDTH  write data
- tb_zero  input  1  high on cycles where the PWM timebase equals 0 (reload cycle)
- prd  output  WIDTH  active period (timebase reloads to prd, period = prd+1 clocks)
- cmp0h, cmp0l  output  WIDTH each  active channel-0 compare values
- cmp1h, cmp1l  output  WIDTH each  active channel-1 compare values
- busy  output  1  commit in progress (state != IDLE)
- upd_done  output  1  one-cycle pulse: active set was updated
- cfg_err  output  1  one-cycle pulse: illegal address or rejected commit

Behaviour:
- Reset is synchronous and active-high. Shadow and active registers reset to prd=8, cmp0h=0, cmp0l=5, cmp1h=4, cmp1l=3. State is IDLE; busy, upd_done and cfg_err are 0.
- A write is accepted on a rising edge where wr_valid && wr_ready. wr_ready = (state==IDLE), purely state-derived and independent of wr_addr and wr_valid.
- Address map:
  - 0 PRD, 1 CMP0H, 2 CMP0L, 3 CMP1H, 4 CMP1L: write the shadow register.
  - 5 COMMIT: wr_data ignored; IDLE->CHECK.
  - 6, 7 reserved: write accepted and discarded; cfg_err pulses the next cycle.
- Shadow writes never affect the active outputs until an update completes.
- FSM states: IDLE, CHECK, ARMED.
  - IDLE: accept writes. A COMMIT moves to CHECK.
  - CHECK: lasts exactly 1 cycle. Legal means every shadow compare <= shadow PRD, and shadow PRD >= 1 (unsigned WIDTH-bit compares).
    - Legal: go to ARMED.
    - Illegal: go to IDLE, pulse cfg_err, leave active registers unchanged. The shadow is retained so the host can correct one field and recommit.
    - tb_zero during CHECK is ignored.
  - ARMED: on the first edge with tb_zero=1, load all five active registers from shadow on that edge. upd_done is high the following cycle; the state returns to IDLE on the same edge.
- Minimum latency from COMMIT accept to upd_done is 3 cycles (CHECK, ARMED with tb_zero already high, done).
- There is no timeout. If tb_zero never asserts, the block stays ARMED and busy.
- Because the timebase samples prd at its reload, a new PRD governs the period after the one starting at the update edge. New compare values apply from the update edge.
- rst during CHECK or ARMED aborts the commit: the state returns to IDLE and all registers take their reset values.
- upd_done and cfg_err are never high in the same cycle.
- All outputs are registered.

Decomposition:
- Shared package pwm_cfg_pkg holds:
  - the address constants ADDR_PRD..ADDR_COMMIT;
  - the state enum typedef;
  - a struct typedef pwm_cfg_t {prd, cmp0h, cmp0l, cmp1h, cmp1l} used for both the shadow and active sets;
  - the reset-default pwm_cfg_t constant.
- One natural sub-module, pwm_cfg_check: a combinational legality check taking a pwm_cfg_t and returning ok. It is reused by any later multi-channel variant.

Test Plan:
- Reset, no writes -> prd=8, cmp0h=0, cmp0l=5, cmp1h=4, cmp1l=3; wr_ready=1; busy=0.
- Write PRD=20, CMP0L=10, then COMMIT with tb_zero held low 10 cycles, then a 1-cycle tb_zero pulse:
  - active outputs stay at defaults until the tb_zero edge, then prd=20, cmp0l=10;
  - upd_done pulses exactly once the next cycle;
  - busy spans CHECK..ARMED.
- Write PRD=4, then COMMIT (cmp0l=5 > 4):
  - cfg_err pulse 2 cycles after the COMMIT accept;
  - no upd_done; active prd remains 8;
  - writing CMP0L=2 then COMMIT succeeds on the next tb_zero.
- COMMIT with tb_zero tied high -> upd_done exactly 3 cycles after the COMMIT accept; wr_ready low for 2 cycles.
- wr_valid held high during ARMED with PRD=50 -> not accepted (wr_ready=0); after upd_done the write is accepted and only the shadow changes.
- Write to address 7 -> cfg_err pulse; shadow, active and state unchanged.
- Assert rst while ARMED -> next cycle: IDLE, defaults restored, no upd_done.
